serial_output_neuron: RTL and testbench

- Time-multiplexed, parametrised output-layer neuron with one multiplier.
- Accepts N_IN (input, weight) pairs, one per beat, over a valid/ready stream. Accumulates the products with saturation onto a per-result bias, applies a selectable activation, and presents one registered result on a valid/ready output.
- Sits between the hidden-layer result stream and the drowsiness decision logic.
- Generalises the fixed 5-input combinational output neuron: configurable input count, widths, fixed-point scaling and activation; adds bias, backpressure, flush and status flags.

---
 rtl/serial_output_neuron.sv | 188 ++++++++++++++++++
 tb/tb_serial_output_neuron.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_output_neuron.sv
// Time-multiplexed output-layer neuron: one multiplier, saturating accumulation onto a bias,
// selectable activation, registered result behind a valid/ready handshake.
module serial_output_neuron #(
    parameter int N_IN      = 5,
    parameter int IN_W      = 10,
    parameter int W_W       = 10,
    parameter int FRAC_BITS = 9,
    parameter int ACC_W     = 16,
    parameter int OUT_W     = 10,
    parameter int ACT_MODE  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_W-1:0]         in_val,
    input  logic signed [W_W-1:0]   in_weight,
    input  logic signed [ACC_W-1:0] bias,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic                    out_acc_sat,
    output logic                    out_clip
);

    localparam int PROD_W = IN_W + W_W + 1;
    localparam int CNT_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
    // Common signed width wide enough for the product, a bias+term sum and the output range.
    localparam int WIDE0  = (PROD_W > ACC_W + 1) ? PROD_W : ACC_W + 1;
    localparam int WIDE   = ((WIDE0 > OUT_W + 1) ? WIDE0 : OUT_W + 1) + 1;

    localparam logic signed [WIDE-1:0] ACC_MAX_W = {{(WIDE-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [WIDE-1:0] ACC_MIN_W = {{(WIDE-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    localparam logic signed [WIDE-1:0] OUT_MAX_W = {{(WIDE-OUT_W){1'b0}}, {OUT_W{1'b1}}};
    localparam logic signed [WIDE-1:0] HALF_W    = {{(WIDE-OUT_W){1'b0}}, 1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_ACT, S_OUT} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      sat_q, sat_d;
    logic                      out_valid_q, out_valid_d;
    logic [OUT_W-1:0]          out_data_q, out_data_d;
    logic                      out_clip_q, out_clip_d;
    logic                      out_sat_q, out_sat_d;

    logic signed [PROD_W-1:0]  prod;
    logic signed [PROD_W-1:0]  scaled;
    logic [ACC_W:0]            scaled_r;
    logic signed [ACC_W-1:0]   scaled_c;
    logic signed [ACC_W-1:0]   base;
    logic [ACC_W:0]            sum_r;
    logic                      beat_sat;
    logic                      beat;
    logic signed [WIDE-1:0]    act_t;
    logic [OUT_W-1:0]          act_data;
    logic                      act_clip;

    // Returns {saturated, value} after clamping a wide signed value into ACC_W bits.
    function automatic logic [ACC_W:0] sat_acc(input logic signed [WIDE-1:0] v);
        if (v > ACC_MAX_W) begin
            return {1'b1, ACC_MAX_W[ACC_W-1:0]};
        end else if (v < ACC_MIN_W) begin
            return {1'b1, ACC_MIN_W[ACC_W-1:0]};
        end else begin
            return {1'b0, v[ACC_W-1:0]};
        end
    endfunction

    always_comb begin
        prod     = PROD_W'($signed({1'b0, in_val})) * PROD_W'(in_weight);
        scaled   = prod >>> FRAC_BITS;
        scaled_r = sat_acc(WIDE'(scaled));
        scaled_c = $signed(scaled_r[ACC_W-1:0]);
        base     = (state_q == S_IDLE) ? bias : acc_q;
        sum_r    = sat_acc(WIDE'(base) + WIDE'(scaled_c));
        beat_sat = scaled_r[ACC_W] | sum_r[ACC_W];
    end

    // Activation is evaluated from the settled accumulator while in the ACT cycle.
    always_comb begin
        act_t = (ACT_MODE == 1) ? WIDE'(acc_q >>> 2) + HALF_W : WIDE'(acc_q);
        if (act_t[WIDE-1]) begin
            act_data = '0;
            act_clip = 1'b1;
        end else if (act_t > OUT_MAX_W) begin
            act_data = OUT_MAX_W[OUT_W-1:0];
            act_clip = 1'b1;
        end else begin
            act_data = act_t[OUT_W-1:0];
            act_clip = 1'b0;
        end
    end

    always_comb begin
        in_ready    = !rst && !flush && (state_q == S_IDLE || state_q == S_ACCUM);
        beat        = in_valid && in_ready;
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_clip_d  = out_clip_q;
        out_sat_d   = out_sat_q;

        case (state_q)
            S_IDLE: begin
                if (beat) begin
                    acc_d = $signed(sum_r[ACC_W-1:0]);
                    sat_d = beat_sat;
                    if (N_IN == 1) begin
                        cnt_d   = '0;
                        state_d = S_ACT;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                if (beat) begin
                    acc_d = $signed(sum_r[ACC_W-1:0]);
                    sat_d = sat_q | beat_sat;
                    if (cnt_q == CNT_W'(N_IN - 1)) begin
                        cnt_d   = '0;
                        state_d = S_ACT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_ACT: begin
                out_data_d  = act_data;
                out_clip_d  = act_clip;
                out_sat_d   = sat_q;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over any beat or output handshake in the same cycle.
        if (flush) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            acc_d       = '0;
            sat_d       = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_clip_q  <= 1'b0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_clip_q  <= out_clip_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_clip    = out_clip_q;
    assign out_acc_sat = out_sat_q;

endmodule

// File: tb/tb_serial_output_neuron.sv
// Bench for serial_output_neuron: directed and random beats checked every cycle against an
// integer reference model; two N_IN=5 instances (both activations) share stimulus, plus one N_IN=1.
module tb_serial_output_neuron;

    localparam int N_IN = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [9:0] in_val = '0;
    logic signed [9:0] in_weight = '0;
    logic signed [15:0] bias = '0;

    logic in_ready0, out_valid0, out_clip0, out_sat0;
    logic in_ready1, out_valid1, out_clip1, out_sat1;
    logic [9:0] out_data0, out_data1;

    logic flush2 = 1'b0;
    logic in_valid2 = 1'b0;
    logic out_ready2 = 1'b1;
    logic [9:0] in_val2 = '0;
    logic signed [9:0] in_weight2 = '0;
    logic signed [15:0] bias2 = '0;
    logic in_ready2, out_valid2, out_clip2, out_sat2;
    logic [9:0] out_data2;

    int total = 0;
    int bad = 0;
    int vec_v[5];
    int vec_w[5];

    serial_output_neuron #(.N_IN(5), .ACT_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
        .in_val(in_val), .in_weight(in_weight), .bias(bias), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0), .out_acc_sat(out_sat0), .out_clip(out_clip0));

    serial_output_neuron #(.N_IN(5), .ACT_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .in_val(in_val), .in_weight(in_weight), .bias(bias), .out_valid(out_valid1),
        .out_ready(out_ready), .out_data(out_data1), .out_acc_sat(out_sat1), .out_clip(out_clip1));

    serial_output_neuron #(.N_IN(1), .ACT_MODE(1)) dut2 (
        .clk(clk), .rst(rst), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_val(in_val2), .in_weight(in_weight2), .bias(bias2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_data(out_data2), .out_acc_sat(out_sat2), .out_clip(out_clip2));

    always #5 clk = ~clk;

    // Reference model: beats collected into a result, one ACT cycle, then held until consumed.
    int     m_beats = 0;
    bit     m_act = 1'b0;
    bit     m_hold = 1'b0;
    longint m_acc = 0;
    bit     m_sat = 1'b0;
    longint e0_data = 0, e1_data = 0;
    bit     e0_clip = 1'b0, e1_clip = 1'b0, e_sat = 1'b0;

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic longint clampl(input longint v, input longint lo, input longint hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        longint prod, scaled, sc, base, sum;
        if (rst) begin
            m_beats = 0; m_act = 0; m_hold = 0; m_acc = 0; m_sat = 0;
        end else if (flush) begin
            m_beats = 0; m_act = 0; m_hold = 0; m_acc = 0; m_sat = 0;
        end else if (m_hold) begin
            if (out_ready) m_hold = 0;
        end else if (m_act) begin
            m_act = 0;
            m_hold = 1;
            e0_data = clampl(m_acc, 0, 1023);
            e0_clip = (e0_data != m_acc);
            e1_data = clampl(floor_div(m_acc, 4) + 512, 0, 1023);
            e1_clip = (e1_data != floor_div(m_acc, 4) + 512);
            e_sat   = m_sat;
        end else if (in_valid) begin
            prod   = longint'(in_val) * longint'(in_weight);
            scaled = floor_div(prod, 512);
            sc     = clampl(scaled, -32768, 32767);
            base   = (m_beats == 0) ? longint'(bias) : m_acc;
            sum    = base + sc;
            m_acc  = clampl(sum, -32768, 32767);
            m_sat  = ((m_beats == 0) ? 1'b0 : m_sat) | (sc != scaled) | (m_acc != sum);
            m_beats = m_beats + 1;
            if (m_beats == N_IN) begin
                m_beats = 0;
                m_act = 1;
            end
        end
    end

    task automatic check_output(input string name, input longint actual, input longint expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        check_output("in_ready0", in_ready0, !rst && !flush && !m_act && !m_hold);
        check_output("in_ready1", in_ready1, !rst && !flush && !m_act && !m_hold);
        check_output("out_valid0", out_valid0, m_hold);
        check_output("out_valid1", out_valid1, m_hold);
        if (m_hold) begin
            check_output("out_data0", out_data0, e0_data);
            check_output("out_clip0", out_clip0, e0_clip);
            check_output("out_sat0", out_sat0, e_sat);
            check_output("out_data1", out_data1, e1_data);
            check_output("out_clip1", out_clip1, e1_clip);
            check_output("out_sat1", out_sat1, e_sat);
        end
        if (rst) begin
            check_output("rst_data0", out_data0, 0);
            check_output("rst_flags0", {out_clip0, out_sat0}, 0);
        end
    end

    // Drives n beats from vec_v/vec_w with random idle gaps; non-first beats carry junk bias.
    task automatic apply_stimulus(input int n, input int b, input int gap_max);
        bit acc;
        int budget;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk); #2;
            end
            in_valid  = 1'b1;
            in_val    = 10'(vec_v[i]);
            in_weight = 10'(vec_w[i]);
            bias      = (i == 0) ? 16'(b) : 16'($urandom);
            budget    = 40;
            acc       = 1'b0;
            while (!acc && budget > 0) begin
                @(negedge clk);
                acc = in_ready0;
                @(posedge clk); #2;
                budget--;
            end
            if (!acc) check_output("beat_timeout", 0, 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int d0, output int d1, output bit c0, output bit s0);
        int budget = 40;
        d0 = -1; d1 = -1; c0 = 0; s0 = 0;
        while (budget > 0) begin
            @(negedge clk);
            if (out_valid0) break;
            budget--;
        end
        if (budget == 0) check_output("result_timeout", 0, 1);
        d0 = int'(out_data0); d1 = int'(out_data1); c0 = out_clip0; s0 = out_sat0;
        @(posedge clk); #2;
    endtask

    task automatic run_single(input int v, input int w, input int b, input int exp_d, input int exp_c);
        int budget = 40;
        in_valid2 = 1'b1; in_val2 = 10'(v); in_weight2 = 10'(w); bias2 = 16'(b);
        while (budget > 0) begin
            @(negedge clk);
            if (in_ready2) break;
            budget--;
        end
        @(posedge clk); #2;
        in_valid2 = 1'b0;
        if (budget == 0) check_output("single_accept_timeout", 0, 1);
        budget = 40;
        while (budget > 0) begin
            @(negedge clk);
            if (out_valid2) break;
            budget--;
        end
        if (budget == 0) check_output("single_result_timeout", 0, 1);
        check_output("single_data", out_data2, exp_d);
        check_output("single_clip", out_clip2, exp_c);
        @(posedge clk); #2;
    endtask

    initial begin
        int d0, d1;
        bit c0, s0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        out_ready = 1'b1;

        // +1.0 is not representable in a 10-bit signed weight, so 511 (~0.998) is used: sum 145.
        vec_v = '{10, 20, 30, 40, 50};
        vec_w = '{511, 511, 511, 511, 511};
        apply_stimulus(5, 0, 0);
        @(negedge clk);
        check_output("latency_act_cycle", out_valid0, 0);
        @(posedge clk); #2;
        @(negedge clk);
        check_output("latency_out_valid", out_valid0, 1);
        check_output("lit_pos_data0", out_data0, 145);
        check_output("lit_pos_data1", out_data1, 548);
        check_output("lit_pos_flags", {out_clip0, out_sat0}, 0);
        @(posedge clk); #2;

        vec_w = '{-512, -512, -512, -512, -512};
        apply_stimulus(5, 0, 2);
        wait_result(d0, d1, c0, s0);
        check_output("lit_neg_data0", d0, 0);
        check_output("lit_neg_clip0", c0, 1);
        check_output("lit_neg_data1", d1, 474);

        vec_v = '{1023, 1023, 1023, 1023, 1023};
        vec_w = '{511, 511, 511, 511, 511};
        apply_stimulus(5, 0, 0);
        wait_result(d0, d1, c0, s0);
        check_output("lit_big_data0", d0, 1023);
        check_output("lit_big_clip0", c0, 1);
        check_output("lit_big_sat0", s0, 0);
        apply_stimulus(5, 32767, 0);
        wait_result(d0, d1, c0, s0);
        check_output("lit_bias_sat0", s0, 1);
        check_output("lit_bias_data0", d0, 1023);

        // Backpressure: result held while further beats are offered and ignored.
        out_ready = 1'b0;
        vec_v = '{10, 20, 30, 40, 50};
        vec_w = '{-512, -512, -512, -512, -512};
        apply_stimulus(5, 0, 0);
        wait_result(d0, d1, c0, s0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_val = 10'($urandom); in_weight = 10'($urandom);
            @(negedge clk);
            check_output("bp_data1", out_data1, 474);
            check_output("bp_in_ready", in_ready0, 0);
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #2;
        @(negedge clk);
        check_output("bp_release_valid", out_valid0, 0);
        check_output("bp_release_ready", in_ready0, 1);
        @(posedge clk); #2;

        // Partial vector with gaps, then flush while a beat is offered.
        vec_v = '{300, 300, 300, 40, 50};
        vec_w = '{200, 200, 200, 511, 511};
        apply_stimulus(3, 500, 3);
        flush = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        check_output("flush_in_ready", in_ready0, 0);
        @(posedge clk); #2;
        flush = 1'b0; in_valid = 1'b0;
        vec_v = '{10, 20, 30, 40, 50};
        vec_w = '{511, 511, 511, 511, 511};
        apply_stimulus(5, 100, 2);
        wait_result(d0, d1, c0, s0);
        check_output("lit_flush_data0", d0, 245);
        check_output("lit_flush_data1", d1, 573);

        // Asynchronous reset in mid-accumulation, then with a result held.
        apply_stimulus(3, 0, 1);
        #1 rst = 1'b1;
        #1 check_output("rst_accum_ready", in_ready0, 0);
        @(posedge clk); #2 rst = 1'b0;
        vec_v = '{1023, 1023, 1023, 1023, 1023};
        out_ready = 1'b0;
        apply_stimulus(5, 0, 0);
        wait_result(d0, d1, c0, s0);
        check_output("lit_pre_rst_data0", d0, 1023);
        #1 rst = 1'b1;
        #1 check_output("rst_held_valid", out_valid0, 0);
        check_output("rst_held_data", out_data0, 0);
        check_output("rst_held_clip", out_clip0, 0);
        @(posedge clk); #2 rst = 1'b0;
        out_ready = 1'b1;
        vec_v = '{10, 20, 30, 40, 50};
        apply_stimulus(5, 0, 1);
        wait_result(d0, d1, c0, s0);
        check_output("lit_post_rst_data0", d0, 145);

        // Random traffic: gaps, backpressure, occasional flush, wide bias range.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_val    = 10'($urandom);
            in_weight = 10'($urandom);
            case ($urandom_range(0, 3))
                0: bias = 16'($urandom);
                1: bias = 16'sd32000;
                2: bias = -16'sd32000;
                default: bias = 16'($signed($urandom_range(0, 2000)) - 1000);
            endcase
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 80) == 0);
            @(posedge clk); #2;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #2;
        end

        run_single(0, 100, 0, 512, 0);
        run_single(1023, 511, 0, 767, 0);
        run_single(0, 0, -32768, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
